// File: rtl/int_issue_queue_if.sv
// -----------------------------------------------------------------------------
// int_issue_queue_if
// Purpose : bundles the dispatch-side enqueue bus, the writeback wakeup bus,
//           the FU issue handshake and the debug free count of the integer
//           issue queue. Signal names are from the queue's point of view
//           (i_* into the queue, o_* out of it).
// Modports: master - dispatch / writeback / FU side (drives i_*, reads o_*)
//           slave  - the issue queue itself (reads i_*, drives o_*)
// Signals : i_squash_vld, o_stall, i_enq_vld/prs1/prs2/rdy1/rdy2/payload,
//           i_wk_vld/prd, i_fu_ready, o_issue_vld, o_issue_payload,
//           o_free_cnt
// -----------------------------------------------------------------------------
interface int_issue_queue_if #(
  parameter int DEPTH      = 8,
  parameter int INPORT_NUM = 2,
  parameter int WAKEUP_NUM = 2,
  parameter int PREG_W     = 7,
  parameter int PAYLOAD_W  = 64
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                            i_squash_vld;
  logic                            o_stall;
  logic [INPORT_NUM-1:0]           i_enq_vld;
  logic [INPORT_NUM*PREG_W-1:0]    i_enq_prs1;
  logic [INPORT_NUM*PREG_W-1:0]    i_enq_prs2;
  logic [INPORT_NUM-1:0]           i_enq_rdy1;
  logic [INPORT_NUM-1:0]           i_enq_rdy2;
  logic [INPORT_NUM*PAYLOAD_W-1:0] i_enq_payload;
  logic [WAKEUP_NUM-1:0]           i_wk_vld;
  logic [WAKEUP_NUM*PREG_W-1:0]    i_wk_prd;
  logic                            i_fu_ready;
  logic                            o_issue_vld;
  logic [PAYLOAD_W-1:0]            o_issue_payload;
  logic [CNT_W-1:0]                o_free_cnt;

  modport master (
    output i_squash_vld, i_enq_vld, i_enq_prs1, i_enq_prs2, i_enq_rdy1,
           i_enq_rdy2, i_enq_payload, i_wk_vld, i_wk_prd, i_fu_ready,
    input  o_stall, o_issue_vld, o_issue_payload, o_free_cnt
  );

  modport slave (
    input  i_squash_vld, i_enq_vld, i_enq_prs1, i_enq_prs2, i_enq_rdy1,
           i_enq_rdy2, i_enq_payload, i_wk_vld, i_wk_prd, i_fu_ready,
    output o_stall, o_issue_vld, o_issue_payload, o_free_cnt
  );
endinterface

// File: rtl/int_issue_queue.sv
// -----------------------------------------------------------------------------
// int_issue_queue
// Purpose : integer issue queue behind the int dispatch queue. Accepts up to
//           INPORT_NUM micro-ops per cycle, tracks two source operands per
//           entry, wakes them from writeback tags and issues the oldest
//           fully-ready entry to one FU port per cycle (age-matrix select).
// Ports   : clk  - clock
//           rst  - synchronous active-high reset
//           bus  - int_issue_queue_if.slave (enqueue, wakeup, issue, stall,
//                  squash and free-count signals)
// Handshakes:
//   enqueue - port k transfers on a clock edge when i_enq_vld[k] && !o_stall
//             && !i_squash_vld; otherwise dispatch must hold the entries.
//   issue   - an entry transfers on a clock edge when o_issue_vld is high;
//             o_issue_vld already includes i_fu_ready and !i_squash_vld.
// -----------------------------------------------------------------------------
module int_issue_queue #(
  parameter int DEPTH      = 8,
  parameter int INPORT_NUM = 2,
  parameter int WAKEUP_NUM = 2,
  parameter int PREG_W     = 7,
  parameter int PAYLOAD_W  = 64
) (
  input logic clk,
  input logic rst,
  int_issue_queue_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]      DEPTH_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      INPORT_CNT = CNT_W'(INPORT_NUM);
  localparam logic [INPORT_NUM-1:0] INP_ONE    = INPORT_NUM'(1);
  localparam logic [DEPTH-1:0]      DEP_ONE    = DEPTH'(1);

  // Entry state
  logic [DEPTH-1:0]     r_valid, r_rdy1, r_rdy2;
  logic [PREG_W-1:0]    r_prs1    [DEPTH];
  logic [PREG_W-1:0]    r_prs2    [DEPTH];
  logic [PAYLOAD_W-1:0] r_payload [DEPTH];
  logic [DEPTH-1:0]     r_age     [DEPTH];  // bit j set: entry j is older
  logic [CNT_W-1:0]     r_free_cnt;
  logic [PAYLOAD_W-1:0] r_last_payload;

  // Interface aliases
  logic                            w_squash, w_fu_ready;
  logic [INPORT_NUM-1:0]           w_enq_vld, w_enq_rdy1, w_enq_rdy2;
  logic [INPORT_NUM*PREG_W-1:0]    w_enq_prs1, w_enq_prs2;
  logic [INPORT_NUM*PAYLOAD_W-1:0] w_enq_payload;
  logic [WAKEUP_NUM-1:0]           w_wk_vld;
  logic [WAKEUP_NUM*PREG_W-1:0]    w_wk_prd;

  assign w_squash      = bus.i_squash_vld;
  assign w_fu_ready    = bus.i_fu_ready;
  assign w_enq_vld     = bus.i_enq_vld;
  assign w_enq_rdy1    = bus.i_enq_rdy1;
  assign w_enq_rdy2    = bus.i_enq_rdy2;
  assign w_enq_prs1    = bus.i_enq_prs1;
  assign w_enq_prs2    = bus.i_enq_prs2;
  assign w_enq_payload = bus.i_enq_payload;
  assign w_wk_vld      = bus.i_wk_vld;
  assign w_wk_prd      = bus.i_wk_prd;

  function automatic logic wk_hit(input logic [PREG_W-1:0] prs,
                                  input logic [WAKEUP_NUM-1:0] vld,
                                  input logic [WAKEUP_NUM*PREG_W-1:0] prd);
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < WAKEUP_NUM; w++)
      if (vld[w] && (prd[w*PREG_W +: PREG_W] == prs)) hit = 1'b1;
    return hit;
  endfunction

  // Wakeup matches for resident entries and for same-cycle enqueues
  logic [DEPTH-1:0]      w_wk1, w_wk2;
  logic [INPORT_NUM-1:0] w_enq_wk1, w_enq_wk2;
  always_comb begin
    w_wk1 = '0;
    w_wk2 = '0;
    w_enq_wk1 = '0;
    w_enq_wk2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_wk1[i] = wk_hit(r_prs1[i], w_wk_vld, w_wk_prd);
      w_wk2[i] = wk_hit(r_prs2[i], w_wk_vld, w_wk_prd);
    end
    for (int k = 0; k < INPORT_NUM; k++) begin
      w_enq_wk1[k] = wk_hit(w_enq_prs1[k*PREG_W +: PREG_W], w_wk_vld, w_wk_prd);
      w_enq_wk2[k] = wk_hit(w_enq_prs2[k*PREG_W +: PREG_W], w_wk_vld, w_wk_prd);
    end
  end

  // Select: a ready entry wins when no older entry is also ready.
  logic [DEPTH-1:0]     w_ready, w_sel, w_iss_oh;
  logic                 w_issue_vld;
  logic [PAYLOAD_W-1:0] w_sel_payload;
  always_comb begin
    w_ready       = r_valid & r_rdy1 & r_rdy2;
    w_sel         = '0;
    w_sel_payload = '0;
    for (int i = 0; i < DEPTH; i++)
      w_sel[i] = w_ready[i] & ~(|(r_age[i] & w_ready));
    for (int i = 0; i < DEPTH; i++)
      if (w_sel[i]) w_sel_payload = w_sel_payload | r_payload[i];
    w_issue_vld = (|w_ready) & w_fu_ready & ~w_squash;
    w_iss_oh    = w_issue_vld ? w_sel : '0;
  end

  // Allocation: port k takes the k-th lowest free slot. Free slots come from
  // the registered valid vector, so a slot freed by this cycle's issue is not
  // reused until next cycle. Each new row marks every surviving resident entry
  // plus lower-numbered same-cycle enqueues as older.
  logic                 w_stall, w_enq_fire;
  logic [CNT_W-1:0]     w_enq_cnt;
  logic [DEPTH-1:0]     w_alloc   [INPORT_NUM];
  logic [DEPTH-1:0]     w_new_age [INPORT_NUM];
  logic [DEPTH-1:0]     w_free_rem, w_older;
  always_comb begin
    w_stall    = r_free_cnt < INPORT_CNT;
    w_enq_fire = ~w_stall & ~w_squash;
    w_enq_cnt  = w_enq_fire ? CNT_W'($countones(w_enq_vld)) : '0;
    w_free_rem = ~r_valid;
    w_older    = r_valid & ~w_iss_oh;
    for (int k = 0; k < INPORT_NUM; k++) begin
      w_alloc[k]   = w_free_rem & (~w_free_rem + DEP_ONE);
      w_free_rem   = w_free_rem & ~w_alloc[k];
      w_new_age[k] = w_older;
      if (w_enq_vld[k]) w_older = w_older | w_alloc[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid        <= '0;
      r_rdy1         <= '0;
      r_rdy2         <= '0;
      r_free_cnt     <= DEPTH_CNT;
      r_last_payload <= '0;
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else if (w_squash) begin
      r_valid    <= '0;
      r_free_cnt <= DEPTH_CNT;
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else begin
      r_free_cnt <= r_free_cnt - w_enq_cnt + CNT_W'(w_issue_vld);
      if (w_issue_vld) r_last_payload <= w_sel_payload;
      for (int i = 0; i < DEPTH; i++) begin
        r_rdy1[i] <= r_rdy1[i] | w_wk1[i];
        r_rdy2[i] <= r_rdy2[i] | w_wk2[i];
        r_age[i]  <= r_age[i] & ~w_iss_oh;
        if (w_iss_oh[i]) r_valid[i] <= 1'b0;
      end
      if (w_enq_fire) begin
        for (int k = 0; k < INPORT_NUM; k++) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (w_enq_vld[k] && w_alloc[k][i]) begin
              r_valid[i]   <= 1'b1;
              r_rdy1[i]    <= w_enq_rdy1[k] | w_enq_wk1[k];
              r_rdy2[i]    <= w_enq_rdy2[k] | w_enq_wk2[k];
              r_prs1[i]    <= w_enq_prs1[k*PREG_W +: PREG_W];
              r_prs2[i]    <= w_enq_prs2[k*PREG_W +: PREG_W];
              r_payload[i] <= w_enq_payload[k*PAYLOAD_W +: PAYLOAD_W];
              r_age[i]     <= w_new_age[k];
            end
          end
        end
      end
    end
  end

  assign bus.o_stall         = w_stall;
  assign bus.o_issue_vld     = w_issue_vld;
  assign bus.o_issue_payload = w_issue_vld ? w_sel_payload : r_last_payload;
  assign bus.o_free_cnt      = r_free_cnt;

  a_enq_packed: assert property (@(posedge clk) disable iff (rst)
    ((w_enq_vld + INP_ONE) & w_enq_vld) == '0);
  a_no_enq_stalled: assert property (@(posedge clk) disable iff (rst)
    !(w_stall && w_enq_fire && (|w_enq_vld)));
  a_free_cnt: assert property (@(posedge clk) disable iff (rst)
    r_free_cnt == CNT_W'(DEPTH - $countones(r_valid)));
endmodule

// File: tb/tb_int_issue_queue.sv
module tb_int_issue_queue;
  localparam int DEPTH = 8;
  localparam int INP   = 2;
  localparam int WKN   = 2;
  localparam int PW    = 7;
  localparam int PLW   = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [PLW-1:0] exp_q[$];

  int_issue_queue_if #(.DEPTH(DEPTH), .INPORT_NUM(INP), .WAKEUP_NUM(WKN),
                       .PREG_W(PW), .PAYLOAD_W(PLW)) bus ();

  int_issue_queue #(.DEPTH(DEPTH), .INPORT_NUM(INP), .WAKEUP_NUM(WKN),
                    .PREG_W(PW), .PAYLOAD_W(PLW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.i_squash_vld  = 1'b0;
    bus.i_enq_vld     = '0;
    bus.i_enq_prs1    = '0;
    bus.i_enq_prs2    = '0;
    bus.i_enq_rdy1    = '0;
    bus.i_enq_rdy2    = '0;
    bus.i_enq_payload = '0;
    bus.i_wk_vld      = '0;
    bus.i_wk_prd      = '0;
  endtask

  task automatic enq(input int k, input logic [PW-1:0] p1, input logic [PW-1:0] p2,
                     input logic r1, input logic r2, input logic [PLW-1:0] pl);
    bus.i_enq_vld[k]              = 1'b1;
    bus.i_enq_prs1[k*PW +: PW]    = p1;
    bus.i_enq_prs2[k*PW +: PW]    = p2;
    bus.i_enq_rdy1[k]             = r1;
    bus.i_enq_rdy2[k]             = r2;
    bus.i_enq_payload[k*PLW +: PLW] = pl;
  endtask

  task automatic wake(input int w, input logic [PW-1:0] prd);
    bus.i_wk_vld[w]          = 1'b1;
    bus.i_wk_prd[w*PW +: PW] = prd;
  endtask

  task automatic chk(input string name, input logic [PLW-1:0] act, input logic [PLW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic vld, input int free, input logic stall);
    #1;
    chk({tag, " issue_vld"}, PLW'(bus.o_issue_vld), PLW'(vld));
    chk({tag, " free_cnt"},  PLW'(bus.o_free_cnt),  PLW'(free));
    chk({tag, " stall"},     PLW'(bus.o_stall),     PLW'(stall));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [PLW-1:0] e;
    if (!rst && bus.o_issue_vld) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL issue_unexpected: got payload %0h expected no issue", bus.o_issue_payload);
      end else begin
        e = exp_q.pop_front();
        if (bus.o_issue_payload !== e) begin
          n_err++;
          $display("FAIL issue_payload: got %0h expected %0h", bus.o_issue_payload, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    clr_in();
    bus.i_fu_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_state("reset", 1'b0, 8, 1'b0);
    chk("reset payload", bus.o_issue_payload, '0);

    // T1: two ready entries issue port-0 first, then port-1
    tick(); clr_in();
    enq(0, 7'd1, 7'd2, 1'b1, 1'b1, 64'h100);
    enq(1, 7'd3, 7'd4, 1'b1, 1'b1, 64'h101);
    exp_q.push_back(64'h100); exp_q.push_back(64'h101);
    chk_state("t1_c1", 1'b0, 8, 1'b0);
    tick(); clr_in(); chk_state("t1_c2", 1'b1, 6, 1'b0);
    tick(); chk_state("t1_c3", 1'b1, 7, 1'b0);
    tick(); chk_state("t1_c4", 1'b0, 8, 1'b0);

    // T2: A waits on prs1=5, B ready issues first; wakeup in cycle 3 -> A in cycle 4
    tick(); clr_in();
    enq(0, 7'd5, 7'd6, 1'b0, 1'b1, 64'h200);
    enq(1, 7'd7, 7'd8, 1'b1, 1'b1, 64'h201);
    exp_q.push_back(64'h201); exp_q.push_back(64'h200);
    chk_state("t2_c1", 1'b0, 8, 1'b0);
    tick(); clr_in(); chk_state("t2_c2", 1'b1, 6, 1'b0);
    tick(); wake(0, 7'd5); chk_state("t2_c3", 1'b0, 7, 1'b0);
    tick(); clr_in(); chk_state("t2_c4", 1'b1, 7, 1'b0);
    tick(); chk_state("t2_c5", 1'b0, 8, 1'b0);

    // T3: same-cycle wakeup on an enqueue makes it ready at once
    tick(); clr_in();
    enq(0, 7'd9, 7'd10, 1'b0, 1'b1, 64'h300);
    wake(1, 7'd9);
    exp_q.push_back(64'h300);
    chk_state("t3_c1", 1'b0, 8, 1'b0);
    tick(); clr_in(); chk_state("t3_c2", 1'b1, 7, 1'b0);
    tick(); chk_state("t3_c3", 1'b0, 8, 1'b0);

    // T4: fill with unready entries, stall at 0 and 1 free, wake all -> age order
    for (int c = 0; c < 4; c++) begin
      tick(); clr_in();
      enq(0, 7'd30, 7'd31, 1'b0, (c != 3), 64'h400 + 64'(2*c));
      enq(1, 7'd30, 7'd31, 1'b0, (c != 3), 64'h401 + 64'(2*c));
      exp_q.push_back(64'h400 + 64'(2*c));
      exp_q.push_back(64'h401 + 64'(2*c));
      chk_state("t4_fill", 1'b0, 8 - 2*c, 1'b0);
    end
    tick(); clr_in();
    wake(0, 7'd30); wake(1, 7'd31);
    enq(0, 7'd40, 7'd41, 1'b1, 1'b1, 64'hBAD);
    enq(1, 7'd40, 7'd41, 1'b1, 1'b1, 64'hBAE);
    chk_state("t4_full", 1'b0, 0, 1'b1);
    tick(); clr_in(); chk_state("t4_i0", 1'b1, 0, 1'b1);
    tick(); chk_state("t4_i1", 1'b1, 1, 1'b1);
    tick(); chk_state("t4_i2", 1'b1, 2, 1'b0);
    for (int i = 0; i < 20 && bus.o_free_cnt != 4'd8; i++) tick();
    chk_state("t4_drain", 1'b0, 8, 1'b0);
    chk("t4 payload hold", bus.o_issue_payload, 64'h407);

    // T5: FU back-pressure holds state; release issues oldest; enq+issue together
    bus.i_fu_ready = 1'b0;
    tick(); clr_in();
    enq(0, 7'd1, 7'd1, 1'b1, 1'b1, 64'h500);
    enq(1, 7'd1, 7'd1, 1'b1, 1'b1, 64'h501);
    exp_q.push_back(64'h500); exp_q.push_back(64'h501);
    chk_state("t5_c1", 1'b0, 8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); clr_in();
      chk_state("t5_hold", 1'b0, 6, 1'b0);
      chk("t5 payload hold", bus.o_issue_payload, 64'h407);
    end
    tick(); bus.i_fu_ready = 1'b1;
    enq(0, 7'd2, 7'd2, 1'b1, 1'b1, 64'h502);
    exp_q.push_back(64'h502);
    chk_state("t5_rel", 1'b1, 6, 1'b0);
    tick(); clr_in(); chk_state("t5_c6", 1'b1, 6, 1'b0);
    tick(); chk_state("t5_c7", 1'b1, 7, 1'b0);
    tick(); chk_state("t5_c8", 1'b0, 8, 1'b0);

    // T6: squash with 5 valid entries plus same-cycle enq and issue request
    bus.i_fu_ready = 1'b0;
    tick(); clr_in();
    enq(0, 7'd1, 7'd1, 1'b1, 1'b1, 64'h600);
    enq(1, 7'd1, 7'd1, 1'b1, 1'b1, 64'h601);
    chk_state("t6_c1", 1'b0, 8, 1'b0);
    tick(); clr_in();
    enq(0, 7'd1, 7'd1, 1'b1, 1'b1, 64'h602);
    enq(1, 7'd1, 7'd1, 1'b1, 1'b1, 64'h603);
    chk_state("t6_c2", 1'b0, 6, 1'b0);
    tick(); clr_in();
    enq(0, 7'd1, 7'd1, 1'b1, 1'b1, 64'h604);
    chk_state("t6_c3", 1'b0, 4, 1'b0);
    tick(); clr_in();
    bus.i_fu_ready = 1'b1;
    bus.i_squash_vld = 1'b1;
    enq(0, 7'd1, 7'd1, 1'b1, 1'b1, 64'h605);
    enq(1, 7'd1, 7'd1, 1'b1, 1'b1, 64'h606);
    chk_state("t6_squash", 1'b0, 3, 1'b0);
    tick(); clr_in(); chk_state("t6_after", 1'b0, 8, 1'b0);
    tick(); chk_state("t6_after2", 1'b0, 8, 1'b0);

    // T7: reset mid-operation drops a resident entry and the held payload
    bus.i_fu_ready = 1'b0;
    tick(); clr_in();
    enq(0, 7'd1, 7'd1, 1'b1, 1'b1, 64'h700);
    chk_state("t7_c1", 1'b0, 8, 1'b0);
    tick(); clr_in(); rst = 1'b1;
    chk_state("t7_rst", 1'b0, 7, 1'b0);
    tick(); rst = 1'b0; bus.i_fu_ready = 1'b1;
    chk_state("t7_after", 1'b0, 8, 1'b0);
    chk("t7 payload", bus.o_issue_payload, '0);
    tick(); chk_state("t7_after2", 1'b0, 8, 1'b0);

    chk("exp_q_empty", PLW'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
